shift_sequencer: RTL and testbench
==================================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle variable left-shift controller built around a fixed shift-left-by-2 step.
//   Accepts an operand and shift amount over a valid/ready handshake.
//   Applies one <<2 step per cycle, or <<1 for an odd final remainder, until the amount is consumed.
//   Returns the result over a second valid/ready handshake.
//   Sits between the decode/ALU control and the shift datapath; it sequences the shift datapath.
// PARAMETERS
//   n   32           data width in bits; power of two, >= 4
//   SW  $clog2(n)    shift-amount width in bits
// PORTS
//   clk           in   1     single clock, all state updates on posedge
//   rst_n         in   1     synchronous reset, active low
//   start_valid   in   1     requester presents num/shamt
//   start_ready   out  1     block can accept a new operation
//   num           in   n     operand, sampled only on start handshake
//   shamt         in   SW    left-shift amount 0..n-1, sampled only on start handshake
//   result        out  n     shifted value; meaningful only while result_valid=1
//   result_valid  out  1     result available
//   result_ready  in   1     consumer takes result
//   busy          out  1     1 whenever state != IDLE
// BEHAVIOUR
//   Clock/reset: one clock. Reset is synchronous and active-low; rst_n is sampled on posedge clk.
//   Reset: rst_n=0 at posedge -> state=IDLE, acc=0, rem=0.
//     Outputs then: start_ready=1, result=0, result_valid=0, busy=0.
//     Reset has priority over every other event, including mid-SHIFT and in DONE.
//   Handshakes:
//     start fires on a posedge with start_valid & start_ready.
//     result fires on a posedge with result_valid & result_ready.
//   FSM states: IDLE, SHIFT, DONE. start_ready = (state==IDLE); result_valid = (state==DONE).
//   IDLE: on start fire: acc<=num, rem<=shamt.
//     shamt==0 -> DONE; else -> SHIFT.
//     No start fire -> stay in IDLE, registers hold.
//   SHIFT, one step per cycle:
//     rem>=2 -> acc<=acc<<2, rem<=rem-2.
//     rem==1 -> acc<=acc<<1, rem<=0.
//     Go to DONE on the edge where rem becomes 0.
//   DONE: acc and result held stable.
//     On result fire -> IDLE; start_ready=1 the following cycle.
//     start_valid is ignored in SHIFT and DONE: no back-to-back acceptance, no queueing.
//   Latency: start fire sampled at end of cycle k -> result_valid=1 in cycle k+1+ceil(shamt/2).
//     Examples: shamt=0 -> k+1; shamt=2 -> k+2; shamt=n-1=31 -> k+17.
//   Arithmetic: logical shift, zero fill from the LSB. Bits shifted past bit n-1 are dropped.
//     No overflow flag. result = acc, width n throughout.
//   num/shamt changes after the start fire do not affect an in-flight operation.
//   Back-pressure: result_ready=0 holds DONE indefinitely with result unchanged.
//   Simultaneous start_valid and result_ready in DONE: only the result fires.
//     The new start is accepted no earlier than the next cycle, in IDLE.
// TESTING
//   1 Reset: rst_n=0 for 2 cycles, then rst_n=1.
//     -> start_ready=1, result_valid=0, busy=0, result=0.
//   2 num=32'h00000001, shamt=0.
//     -> result_valid in cycle k+1, result=32'h00000001.
//   3 num=32'h13579BDF, shamt=2.
//     -> result_valid at k+2, result=32'h4D5E6F7C.
//   4 num=32'h11111111, shamt=5, odd remainder path.
//     -> result_valid at k+4, result=32'h22222220.
//   5 num=32'hFFFFFFFF, shamt=31.
//     -> result_valid at k+17, result=32'h80000000, MSBs dropped.
//     Then hold result_ready=0 for 5 cycles while pulsing start_valid
//     -> result stable, start_ready=0, no new operation accepted.
//   6 Start num=32'hF0000000, shamt=20; drive rst_n=0 on the 3rd SHIFT cycle.
//     -> next edge: IDLE, busy=0, result=0, result_valid=0.
//     A following op num=1, shamt=4 -> result=32'h00000010 at k+3.

Source files
------------

// File: rtl/shift_sequencer.sv
// Variable left-shift sequencer: one <<2 step per cycle, a final <<1 for odd amounts.
// Operand and amount arrive on a valid/ready handshake; result leaves on another.
module shift_sequencer #(
    parameter int n  = 32,
    parameter int SW = $clog2(n)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start_valid,
    output logic          start_ready,
    input  logic [n-1:0]  num,
    input  logic [SW-1:0] shamt,
    output logic [n-1:0]  result,
    output logic          result_valid,
    input  logic          result_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t        state;
    logic [n-1:0]  acc;
    logic [SW-1:0] rem;

    assign start_ready  = (state == IDLE);
    assign result_valid = (state == DONE);
    assign busy         = (state != IDLE);
    assign result       = acc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            acc   <= '0;
            rem   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_valid) begin
                        acc   <= num;
                        rem   <= shamt;
                        state <= (shamt == '0) ? DONE : SHIFT;
                    end
                end
                SHIFT: begin
                    // rem is never 0 here: a zero amount skips straight to DONE
                    if (rem >= SW'(2)) begin
                        acc <= acc << 2;
                        rem <= rem - SW'(2);
                        if (rem == SW'(2)) state <= DONE;
                    end else begin
                        acc   <= acc << 1;
                        rem   <= '0;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (result_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer: vector table, corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [31:0] num;
    logic [4:0]  shamt;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_sequencer #(.n(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_valid  (start_valid),
        .start_ready  (start_ready),
        .num          (num),
        .shamt        (shamt),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .busy         (busy)
    );

    typedef struct {
        logic [31:0] a;
        logic [4:0]  s;
        logic [31:0] exp_r;
        int          exp_lat;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Issue an operation and wait until DONE; latency counted from the fire edge.
    task automatic start_and_wait(input logic [31:0] a, input logic [4:0] s,
                                  input logic [31:0] exp_r, input int exp_lat);
        int lat;
        @(negedge clk);
        check("start_ready_idle", 32'(start_ready), 32'd1);
        num = a;
        shamt = s;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        num = $urandom;
        shamt = 5'($urandom);
        lat = 1;
        while (!result_valid && lat < 64) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", result, exp_r);
        check("busy_done", 32'(busy), 32'd1);
    endtask

    task automatic consume();
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        result_ready = 1'b0;
        check("start_ready_after", 32'(start_ready), 32'd1);
        check("valid_after", 32'(result_valid), 32'd0);
    endtask

    task automatic run_op(input logic [31:0] a, input logic [4:0] s,
                          input logic [31:0] exp_r, input int exp_lat,
                          input int hold);
        start_and_wait(a, s, exp_r, exp_lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("held_result", result, exp_r);
            check("held_valid", 32'(result_valid), 32'd1);
        end
        consume();
    endtask

    vec_t vecs[5];

    initial begin
        logic [31:0] a;
        logic [4:0]  s;

        vecs[0] = '{32'h00000001, 5'd0,  32'h00000001, 1};
        vecs[1] = '{32'h13579BDF, 5'd2,  32'h4D5E6F7C, 2};
        vecs[2] = '{32'h11111111, 5'd5,  32'h22222220, 4};
        vecs[3] = '{32'hFFFFFFFF, 5'd31, 32'h80000000, 17};
        vecs[4] = '{32'h00000001, 5'd4,  32'h00000010, 3};

        rst_n = 1'b0;
        start_valid = 1'b0;
        result_ready = 1'b0;
        num = '0;
        shamt = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_start_ready", 32'(start_ready), 32'd1);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_result", result, 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].s, vecs[i].exp_r, vecs[i].exp_lat, 0);

        // Back-pressure in DONE while start_valid pulses
        start_and_wait(32'hFFFFFFFF, 5'd31, 32'h80000000, 17);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start_valid = ~start_valid;
            num = 32'h0000_00AA;
            shamt = 5'd1;
            check("bp_result", result, 32'h80000000);
            check("bp_start_ready", 32'(start_ready), 32'd0);
            check("bp_valid", 32'(result_valid), 32'd1);
        end
        // start_valid and result_ready together: only the result fires
        @(negedge clk);
        start_valid = 1'b1;
        result_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        result_ready = 1'b0;
        check("sim_valid", 32'(result_valid), 32'd0);
        check("sim_busy", 32'(busy), 32'd0);
        check("sim_start_ready", 32'(start_ready), 32'd1);
        @(negedge clk);
        check("sim_no_accept", 32'(busy), 32'd0);

        // Reset in the middle of SHIFT
        @(negedge clk);
        num = 32'hF0000000;
        shamt = 5'd20;
        start_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_result", result, 32'd0);
        check("mid_rst_valid", 32'(result_valid), 32'd0);
        check("mid_rst_start_ready", 32'(start_ready), 32'd1);
        rst_n = 1'b1;
        run_op(32'h00000001, 5'd4, 32'h00000010, 3, 0);

        // Random operations against the arithmetic model
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            s = 5'($urandom_range(0, 31));
            run_op(a, s, a << s, 1 + (int'(s) + 1) / 2,
                   int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
